// File: rtl/video_pkg.sv
// Shared video constants, column index type and address-width helper used by
// the line buffer and its row stores.
package video_pkg;

    localparam int PIX_BITS   = 10;
    localparam int LINE_WIDTH = 640;

    // Address width for a store of n entries; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(LINE_WIDTH)-1:0] col_t;

endpackage

// File: rtl/line_ram.sv
// One row store: simple dual-port, read-first, one-cycle registered read.
// The array itself is never reset; only the read register is.
module line_ram
    import video_pkg::*;
#(
    parameter int BITS  = PIX_BITS,
    parameter int DEPTH = LINE_WIDTH,
    parameter int AW    = addr_w(LINE_WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [BITS-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [BITS-1:0] rdata
);

    logic [BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the same address returns the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_buffer.sv
// Streaming multi-line buffer: LINES rotating row stores present a vertical
// column of LINES+1 taps per accepted pixel, with frame/line tracking.
module line_buffer
    import video_pkg::*;
#(
    parameter int BITS  = PIX_BITS,
    parameter int WIDTH = LINE_WIDTH,
    parameter int LINES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic                      in_eol,
    input  logic [BITS-1:0]           in_data,
    output logic                      out_valid,
    output logic [(LINES+1)*BITS-1:0] out_taps,
    output logic [addr_w(WIDTH)-1:0]  out_x,
    output logic [LINES:0]            out_rows_valid,
    output logic                      err_long_line
);

    localparam int AW  = addr_w(WIDTH);
    localparam int WPW = addr_w(LINES);
    localparam int FCW = addr_w(LINES + 1);

    localparam logic [AW-1:0]  X_LAST  = AW'(WIDTH - 1);
    localparam logic [WPW-1:0] WP_LAST = WPW'(LINES - 1);
    localparam logic [FCW-1:0] FC_MAX  = FCW'(LINES);

    logic [AW-1:0]   x_p0, x_eff;
    logic [WPW-1:0]  wp_p0, wp_eff;
    logic [FCW-1:0]  fc_p0, fc_eff;
    logic            accept, line_end, overflow;
    logic [LINES:0]  rows_eff;
    logic            err_p0;

    logic            vld_p1;
    logic [AW-1:0]   x_p1;
    logic [WPW-1:0]  wp_p1;
    logic [LINES:0]  rows_p1;
    logic [BITS-1:0] tap0_p1;
    logic [BITS-1:0] rd_p1 [LINES];

    // Store holding the row k lines above the current one, given the write row.
    function automatic logic [WPW-1:0] rot_idx(input logic [WPW-1:0] wp, input int k);
        int t;
        t = int'(wp) + LINES - k;
        if (t >= LINES) begin
            t = t - LINES;
        end
        return WPW'(t);
    endfunction

    // ---- stage p0: accept, position tracking, store access ----
    always_comb begin
        accept   = in_valid;
        x_eff    = in_sof ? '0 : x_p0;
        wp_eff   = in_sof ? '0 : wp_p0;
        fc_eff   = in_sof ? '0 : fc_p0;
        line_end = in_eol || (x_eff == X_LAST);
        overflow = accept && (x_eff == X_LAST) && !in_eol;
        rows_eff = '0;
        rows_eff[0] = 1'b1;
        for (int k = 1; k <= LINES; k++) begin
            rows_eff[k] = (fc_eff >= FCW'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p0   <= '0;
            wp_p0  <= '0;
            fc_p0  <= '0;
            err_p0 <= 1'b0;
        end else if (accept) begin
            if (line_end) begin
                x_p0  <= '0;
                wp_p0 <= (wp_eff == WP_LAST) ? '0 : wp_eff + 1'b1;
                fc_p0 <= (fc_eff == FC_MAX) ? fc_eff : fc_eff + 1'b1;
            end else begin
                x_p0  <= x_eff + 1'b1;
                wp_p0 <= wp_eff;
                fc_p0 <= fc_eff;
            end
            // A new frame clears the sticky error even if it coincides with an overflow.
            if (in_sof) begin
                err_p0 <= 1'b0;
            end else if (overflow) begin
                err_p0 <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LINES; i++) begin : g_row
        line_ram #(
            .BITS  (BITS),
            .DEPTH (WIDTH),
            .AW    (AW)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (accept && (wp_eff == WPW'(i))),
            .waddr (x_eff),
            .wdata (in_data),
            .re    (accept),
            .raddr (x_eff),
            .rdata (rd_p1[i])
        );
    end

    // ---- stage p1: output registers and tap rotation ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            x_p1    <= '0;
            wp_p1   <= '0;
            rows_p1 <= '0;
            tap0_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                x_p1    <= x_eff;
                wp_p1   <= wp_eff;
                rows_p1 <= rows_eff;
                tap0_p1 <= in_data;
            end
        end
    end

    always_comb begin
        out_taps = '0;
        out_taps[BITS-1:0] = tap0_p1;
        for (int k = 1; k <= LINES; k++) begin
            out_taps[k*BITS +: BITS] = rd_p1[rot_idx(wp_p1, k)];
        end
    end

    assign out_valid      = vld_p1;
    assign out_x          = x_p1;
    assign out_rows_valid = rows_p1;
    assign err_long_line  = err_p0;

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer (WIDTH=8, LINES=2, BITS=10): directed
// vectors, hand-written corner sequences and a random stream against a model.
module tb_line_buffer;

    localparam int BITS  = 10;
    localparam int WIDTH = 8;
    localparam int LINES = 2;
    localparam int AW    = 3;
    localparam int TW    = (LINES + 1) * BITS;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_sof, in_eol;
    logic [BITS-1:0] in_data;
    logic            out_valid;
    logic [TW-1:0]   out_taps;
    logic [AW-1:0]   out_x;
    logic [LINES:0]  out_rows_valid;
    logic            err_long_line;

    always #5 clk = ~clk;

    line_buffer #(.BITS(BITS), .WIDTH(WIDTH), .LINES(LINES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .in_eol         (in_eol),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_taps       (out_taps),
        .out_x          (out_x),
        .out_rows_valid (out_rows_valid),
        .err_long_line  (err_long_line)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame position plus the last value written to each
    // (row-slot, column); slots never written since time zero are unknown.
    int          mx, mwp, mfc;
    bit          merr;
    int          mem   [LINES][WIDTH];
    bit          known [LINES][WIDTH];
    logic [TW-1:0]  e_taps = '0;
    logic [TW-1:0]  e_mask = '1;
    int             e_x;
    logic [LINES:0] e_rows;

    task automatic model_reset();
        mx = 0; mwp = 0; mfc = 0; merr = 1'b0;
        e_taps = '0; e_mask = '1;
    endtask

    task automatic model_accept(input bit s, input bit e, input int d);
        if (s) begin
            mx = 0; mwp = 0; mfc = 0; merr = 1'b0;
        end
        e_x = mx;
        e_taps = '0;
        e_mask = '0;
        e_taps[BITS-1:0] = BITS'(d);
        e_mask[BITS-1:0] = '1;
        e_rows = '0;
        e_rows[0] = 1'b1;
        for (int k = 1; k <= LINES; k++) begin
            int r;
            r = (mwp - k + LINES) % LINES;
            if (known[r][mx]) begin
                e_taps[k*BITS +: BITS] = BITS'(mem[r][mx]);
                e_mask[k*BITS +: BITS] = '1;
            end
            e_rows[k] = (mfc >= k);
        end
        mem[mwp][mx] = d;
        known[mwp][mx] = 1'b1;
        if (mx == WIDTH - 1 && !e) merr = 1'b1;
        if (e || mx == WIDTH - 1) begin
            mx = 0;
            mwp = (mwp + 1) % LINES;
            mfc = (mfc + 1 > LINES) ? LINES : mfc + 1;
        end else begin
            mx = mx + 1;
        end
    endtask

    task automatic step(input bit v, input bit s, input bit e, input int d);
        in_valid = v; in_sof = s; in_eol = e; in_data = BITS'(d);
        if (v) model_accept(s, e, d);
        @(posedge clk);
        #1;
        chk("valid", out_valid, v);
        chk("taps", out_taps & e_mask, e_taps);
        if (v) begin
            chk("x", out_x, e_x);
            chk("rows", out_rows_valid, e_rows);
        end
        chk("err", err_long_line, merr);
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    endtask

    task automatic stream_rows(input int nrows, input int base);
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < WIDTH; c++)
                step(1'b1, (r == 0 && c == 0), (c == WIDTH - 1), base + 16 * r + c);
    endtask

    typedef struct {
        bit             v, s, e;
        int             d;
        int             ex;
        logic [LINES:0] erows;
        bit             eerr;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [TW-1:0] want;

        // Long-line / sof vectors: 9 pixels without eol, a gap, sof, sof+eol.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{v:1, s:(i == 0), e:0, d:'h40 + i, ex:i, erows:3'b001, eerr:(i == 7)};
        tbl[8]  = '{v:1, s:0, e:0, d:'h48,  ex:0, erows:3'b011, eerr:1};
        tbl[9]  = '{v:0, s:0, e:0, d:'h0,   ex:0, erows:3'b000, eerr:1};
        tbl[10] = '{v:1, s:1, e:0, d:'h3ff, ex:0, erows:3'b001, eerr:0};
        tbl[11] = '{v:1, s:1, e:1, d:'h2aa, ex:0, erows:3'b001, eerr:0};
        tbl[12] = '{v:1, s:0, e:0, d:'h155, ex:0, erows:3'b011, eerr:0};
        tbl[13] = '{v:1, s:0, e:1, d:'h0f0, ex:1, erows:3'b011, eerr:0};

        for (int l = 0; l < LINES; l++)
            for (int c = 0; c < WIDTH; c++)
                known[l][c] = 1'b0;

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_taps", out_taps, 0);
        chk("rst_x", out_x, 0);
        chk("rst_rows", out_rows_valid, 0);
        chk("rst_err", err_long_line, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three full lines, pixel = 16*row + col.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < WIDTH; c++) begin
                step(1'b1, (r == 0 && c == 0), (c == WIDTH - 1), 16 * r + c);
                if (r == 0 && c == 0) chk("row0_rows", out_rows_valid, 3'b001);
                if (r == 1 && c == 0) chk("row1_rows", out_rows_valid, 3'b011);
                if (r == 2 && c == 5) begin
                    want = {10'h005, 10'h015, 10'h025};
                    chk("r2c5_taps", out_taps, want);
                    chk("r2c5_rows", out_rows_valid, 3'b111);
                end
            end
        step(1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
            chk("tbl_valid", out_valid, tbl[i].v);
            if (tbl[i].v) begin
                chk("tbl_x", out_x, tbl[i].ex);
                chk("tbl_rows", out_rows_valid, tbl[i].erows);
            end
            chk("tbl_err", err_long_line, tbl[i].eerr);
        end

        // Short line of 5, then a full line.
        for (int c = 0; c < 5; c++) step(1'b1, (c == 0), (c == 4), 100 + c);
        for (int c = 0; c < WIDTH; c++) begin
            step(1'b1, 1'b0, (c == WIDTH - 1), 200 + c);
            if (c == 3) chk("short_tap1", out_taps[BITS +: BITS], 103);
            if (c == 6) begin
                chk("short_err", err_long_line, 0);
                chk("short_rows1", out_rows_valid[1], 1);
            end
        end

        // Gappy stream.
        step(1'b1, 1'b1, 1'b0, 'h111);
        for (int i = 0; i < 200; i++)
            step(1'(($urandom % 2)), 1'b0, 1'(($urandom % 8) == 0), int'($urandom % 1024));

        // Reset in the middle of row 2.
        stream_rows(2, 'h80);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 'h1a0 + c);
        in_valid = 1'b1; in_data = 'h1ff;
        #2;
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_taps", out_taps, 0);
        chk("mid_rst_x", out_x, 0);
        chk("mid_rst_rows", out_rows_valid, 0);
        chk("mid_rst_err", err_long_line, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < WIDTH; c++) begin
            step(1'b1, (c == 0), (c == WIDTH - 1), 'h300 + c);
            if (c == 3) chk("post_rst_rows", out_rows_valid, 3'b001);
        end

        // sof in the middle of row 3.
        stream_rows(3, 'h20);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 'h2c0 + c);
        step(1'b1, 1'b1, 1'b0, 'h3aa);
        chk("midsof_x", out_x, 0);
        chk("midsof_rows", out_rows_valid, 3'b001);

        // Random stream with gaps, eol, occasional sof and overflows.
        for (int i = 0; i < 1500; i++)
            step(1'(($urandom % 4) != 0), 1'(($urandom % 150) == 0),
                 1'(($urandom % 9) == 0), int'($urandom % 1024));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
